sm_mmio_responder: RTL and testbench
====================================

# sm_mmio_responder

Data-side responder for the schoolMIPS single-cycle core: it answers the CPU's `dmAddr/dmWe/dmWData/dmRData` port. Requests are split by address between a word RAM and a small MMIO register window. The window holds a GPIO output register, a synchronized GPIO input, and a prescaled compare-match timer with an interrupt line. The block sits beside instruction memory in the top level and replaces the plain data RAM.

## Interface
- `RAM_AW`, default 6: RAM word-address width; 2^RAM_AW 32-bit words.
- `GPIO_W`, default 8: width of GPIO in/out, 1..32.

- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `dmAddr`  in  32: word address from the CPU.
- `dmWe`  in  1: write enable, sampled on posedge `clk`.
- `dmWData`  in  32: write data.
- `dmRData`  out  32: read data, combinational from `dmAddr`.
- `gpio_in`  in  GPIO_W: asynchronous external inputs.
- `gpio_out`  out  GPIO_W: registered outputs.
- `timer_irq`  out  1: `STAT.match & CTRL.irq_en`, registered-level.

## Operation
- Decode uses `dmAddr[15:0]`; bits 31:16 are ignored (aliasing).
  - `dmAddr[15]==0`: RAM word `dmAddr[RAM_AW-1:0]`, higher bits alias.
  - `dmAddr[15]==1`: MMIO register selected by `dmAddr[3:0]`.
- MMIO map (offset from 0x8000):
  - 0 GPIO_OUT: R/W, GPIO_W bits.
  - 1 GPIO_IN: RO, 2-flop synchronized.
  - 2 CTRL: R/W; bit0 `en`, bit1 `irq_en`.
  - 3 PRESC: R/W, 16 bits.
  - 4 CMP: R/W, 32 bits.
  - 5 CNT: R/W, 32 bits.
  - 6 STAT: bit0 `match`, sticky; writing 1 clears it, writing 0 has no effect.
  - Any other offset reads 0 and ignores writes.
- Unused upper bits of narrow registers read 0.
- RAM is not reset; its contents are undefined until written.
- Timer:
  - When `en=0`, the prescaler counter `pcnt` is held at 0 and CNT holds its value.
  - When `en=1`, `pcnt` counts 0..PRESC and asserts `tick` in the cycle `pcnt==PRESC`; it then returns to 0. With PRESC=0, `tick` fires every cycle.
  - On `tick` with `CNT==CMP`: CNT<=0 and `match`<=1. Otherwise CNT<=CNT+1, wrapping 0xFFFFFFFF->0.
- Simultaneous events:
  - A CPU write to CNT in a tick cycle wins over the increment or reload.
  - A set of `match` in the same cycle as a W1C write wins, so `match` stays 1.
  - A write to CMP or PRESC is used from the next cycle.
  - Clearing `en` in a tick cycle still applies that tick.

## Timing
- Writes commit on the posedge where `dmWe=1`. A read in the following cycle returns the new value.
- Reads are zero-latency combinational, as required by the single-cycle core. There is no handshake and no wait states.
- `gpio_in` reaches GPIO_IN reads 2 clock edges after it changes.
- The `match` flag, and `timer_irq` when `irq_en=1`, rise on the edge that performs the CNT==CMP reload.
- On `rst_n` low, immediately and without a clock:
  - `gpio_out` = 0, CTRL = 0, PRESC = 0, CMP = 0, CNT = 0, `match` = 0, `pcnt` = 0, sync flops = 0.
  - `timer_irq` = 0.
- A reset during counting abandons the count; after release the timer stays idle until CTRL is written.

## Structure
- Shared header `sm_mmio.vh` holds:
  - the register offset defines (`MMIO_GPIO_OUT`..`MMIO_STAT`);
  - the window-select bit;
  - the CTRL/STAT bit positions.
- Top-level RTL and the C/asm test sources both use it.
- Sub-module `sm_mmio_timer` holds PRESC/CMP/CNT/CTRL/STAT, the prescaler and the irq. Its inputs are a register-write strobe, an offset and data; its output is read data.
- GPIO, RAM and the decode/read mux stay in the top.

## Test plan
- Write 0x12345678 to RAM word 5, then read word 5 and word 5+2^RAM_AW -> 0x12345678 both (alias).
- Write 0xA5 to 0x8000 -> `gpio_out`=0xA5 after the edge. Drive `gpio_in`=0x3C -> 0x8001 reads 0x3C from the 2nd edge on, 0 before.
- PRESC=2, CMP=3, CTRL=1 -> CNT increments every 3 cycles 0,1,2,3,0. `match`=1 at the 3→0 reload, 12 cycles after enable.
- With `irq_en`=1 and `match`=1: write STAT=1 -> `timer_irq` falls next edge. Repeat the W1C write in the exact reload cycle -> `match` stays 1.
- CPU writes CNT=100 in a tick cycle -> CNT reads 100, not the increment. CNT=0xFFFFFFFF with CMP=0 -> wraps to 0 with no match that tick.
- Assert `rst_n` mid-count with no clock edge -> all outputs and registers 0 immediately. Reads of offset 7..15 -> 0.

Source files
------------

// File: rtl/sm_mmio_pkg.sv
// Shared definitions for the schoolMIPS data-side responder: window-select
// bit, MMIO register offsets and CTRL/STAT bit positions.
package sm_mmio_pkg;

    localparam int unsigned MMIO_SEL_BIT    = 15;
    localparam int unsigned MMIO_OFF_W      = 4;
    localparam int unsigned PRESC_W         = 16;
    localparam int unsigned DATA_W          = 32;

    localparam logic [MMIO_OFF_W-1:0] MMIO_GPIO_OUT = 4'd0;
    localparam logic [MMIO_OFF_W-1:0] MMIO_GPIO_IN  = 4'd1;
    localparam logic [MMIO_OFF_W-1:0] MMIO_CTRL     = 4'd2;
    localparam logic [MMIO_OFF_W-1:0] MMIO_PRESC    = 4'd3;
    localparam logic [MMIO_OFF_W-1:0] MMIO_CMP      = 4'd4;
    localparam logic [MMIO_OFF_W-1:0] MMIO_CNT      = 4'd5;
    localparam logic [MMIO_OFF_W-1:0] MMIO_STAT     = 4'd6;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned STAT_MATCH_BIT  = 0;

    // Timer control register payload.
    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/sm_mmio_timer.sv
// Prescaled compare-match timer: CTRL/PRESC/CMP/CNT/STAT registers,
// prescaler counter and registered interrupt level.
// Ports: clk, rst_n; wr_i/off_i/wdata_i register-write strobe, offset and
// data; rdata_c_o combinational read data for off_i; irq_o registered irq.
module sm_mmio_timer
    import sm_mmio_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [MMIO_OFF_W-1:0] off_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_c_o,
    output logic                  irq_o
);

    ctrl_t                ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   pcnt_q,  pcnt_d;
    logic [DATA_W-1:0]    cmp_q,   cmp_d;
    logic [DATA_W-1:0]    cnt_q,   cnt_d;
    logic                 match_q, match_d;
    logic                 irq_q,   irq_d;
    logic                 tick_c;
    logic                 hit_c;

    assign tick_c = ctrl_q.en && (pcnt_q == presc_q);
    assign hit_c  = (cnt_q == cmp_q);

    // Next-state: timer progress first, CPU writes override, match set last.
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        match_d = match_q;

        if (!ctrl_q.en || tick_c) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end

        if (tick_c) begin
            cnt_d = hit_c ? '0 : cnt_q + DATA_W'(1);
        end

        if (wr_i) begin
            case (off_i)
                MMIO_CTRL: begin
                    ctrl_d.en     = wdata_i[CTRL_EN_BIT];
                    ctrl_d.irq_en = wdata_i[CTRL_IRQ_EN_BIT];
                end
                MMIO_PRESC: presc_d = wdata_i[PRESC_W-1:0];
                MMIO_CMP:   cmp_d   = wdata_i;
                MMIO_CNT:   cnt_d   = wdata_i;
                MMIO_STAT: begin
                    if (wdata_i[STAT_MATCH_BIT]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A reload beats a same-cycle W1C clear.
        if (tick_c && hit_c) begin
            match_d = 1'b1;
        end

        irq_d = match_d & ctrl_d.irq_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    // Register read mux; narrow registers zero-extended.
    always_comb begin
        rdata_c_o = '0;
        case (off_i)
            MMIO_CTRL:  rdata_c_o = DATA_W'(ctrl_q);
            MMIO_PRESC: rdata_c_o = DATA_W'(presc_q);
            MMIO_CMP:   rdata_c_o = cmp_q;
            MMIO_CNT:   rdata_c_o = cnt_q;
            MMIO_STAT:  rdata_c_o = DATA_W'(match_q);
            default:    rdata_c_o = '0;
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/sm_mmio_responder.sv
// Data-side responder for the schoolMIPS single-cycle core: word RAM plus an
// MMIO window (GPIO out, synchronized GPIO in, compare-match timer).
// Ports: clk, rst_n; dmAddr/dmWe/dmWData CPU request; dmRData combinational
// read data; gpio_in async inputs; gpio_out registered outputs; timer_irq.
module sm_mmio_responder
    import sm_mmio_pkg::*;
#(
    parameter int unsigned RAM_AW = 6,
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

    logic [DATA_W-1:0]     mem_q [RAM_WORDS];
    logic [GPIO_W-1:0]     gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0]     sync1_q, sync2_q;
    logic                  sel_mmio_c;
    logic [MMIO_OFF_W-1:0] off_c;
    logic [RAM_AW-1:0]     ram_idx_c;
    logic                  mmio_wr_c;
    logic [DATA_W-1:0]     timer_rdata_c;
    logic                  unused_addr_c;

    // Upper address bits alias by design.
    assign unused_addr_c = ^dmAddr;

    assign sel_mmio_c = dmAddr[MMIO_SEL_BIT];
    assign off_c      = dmAddr[MMIO_OFF_W-1:0];
    assign ram_idx_c  = dmAddr[RAM_AW-1:0];
    assign mmio_wr_c  = dmWe && sel_mmio_c;

    // Word RAM, intentionally not reset.
    always_ff @(posedge clk) begin
        if (dmWe && !sel_mmio_c) begin
            mem_q[ram_idx_c] <= dmWData;
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (mmio_wr_c && (off_c == MMIO_GPIO_OUT)) begin
            gpio_out_d = dmWData[GPIO_W-1:0];
        end
    end

    // GPIO output register and 2-flop input synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
        end
    end

    sm_mmio_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (mmio_wr_c),
        .off_i     (off_c),
        .wdata_i   (dmWData),
        .rdata_c_o (timer_rdata_c),
        .irq_o     (timer_irq)
    );

    // Zero-latency read mux for the single-cycle core.
    always_comb begin
        dmRData = '0;
        if (!sel_mmio_c) begin
            dmRData = mem_q[ram_idx_c];
        end else begin
            case (off_c)
                MMIO_GPIO_OUT: dmRData = DATA_W'(gpio_out_q);
                MMIO_GPIO_IN:  dmRData = DATA_W'(sync2_q);
                default:       dmRData = timer_rdata_c;
            endcase
        end
    end

    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_sm_mmio_responder.sv
// Directed bench for sm_mmio_responder: RAM aliasing, GPIO, timer sequencing,
// W1C/reload race, CNT write race, wrap, unused offsets and async reset.
module tb_sm_mmio_responder;

    localparam int unsigned RAM_AW = 6;
    localparam int unsigned GPIO_W = 8;

    localparam logic [31:0] A_GPO   = 32'h0000_8000;
    localparam logic [31:0] A_GPI   = 32'h0000_8001;
    localparam logic [31:0] A_CTRL  = 32'h0000_8002;
    localparam logic [31:0] A_PRESC = 32'h0000_8003;
    localparam logic [31:0] A_CMP   = 32'h0000_8004;
    localparam logic [31:0] A_CNT   = 32'h0000_8005;
    localparam logic [31:0] A_STAT  = 32'h0000_8006;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       dmAddr;
    logic              dmWe;
    logic [31:0]       dmWData;
    logic [31:0]       dmRData;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;

    int tests = 0;
    int fails = 0;

    sm_mmio_responder #(.RAM_AW(RAM_AW), .GPIO_W(GPIO_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmAddr    (dmAddr),
        .dmWe      (dmWe),
        .dmWData   (dmWData),
        .dmRData   (dmRData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write commits on the next posedge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmAddr  = a;
        dmWData = d;
        dmWe    = 1'b1;
        @(posedge clk);
        #1;
        dmWe    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dmAddr = a;
        #1;
        check(tag, dmRData, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        dmWe    = 1'b0;
        dmAddr  = '0;
        dmWData = '0;
        gpio_in = '0;
        #3;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_cnt", A_CNT, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // RAM and aliasing
        wr(32'd5, 32'h1234_5678);
        rd_chk("ram_w5", 32'd5, 32'h1234_5678);
        rd_chk("ram_alias_aw", 32'd5 + 32'(2 ** RAM_AW), 32'h1234_5678);
        rd_chk("ram_alias_hi", 32'hABCD_0005, 32'h1234_5678);

        // GPIO
        wr(A_GPO, 32'hFFFF_FFA5);
        check("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd_chk("gpio_out_rd", A_GPO, 32'h0000_00A5);
        gpio_in = 8'h3C;
        rd_chk("gpi_edge0", A_GPI, 32'h0);
        step();
        rd_chk("gpi_edge1", A_GPI, 32'h0);
        step();
        rd_chk("gpi_edge2", A_GPI, 32'h3C);
        rd_chk("gpi_alias", 32'h7777_8001, 32'h3C);

        // Timer PRESC=2, CMP=3: ticks every 3rd edge after enable
        wr(A_PRESC, 32'hDEAD_0002);
        rd_chk("presc_narrow", A_PRESC, 32'h2);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'hFFFF_FFF1);
        rd_chk("ctrl_narrow", A_CTRL, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            step();
            rd_chk($sformatf("cnt_k%0d", k), A_CNT, (k < 12) ? 32'(k / 3) : 32'h0);
            if (k == 11) rd_chk("stat_pre", A_STAT, 32'h0);
            if (k == 12) rd_chk("stat_match", A_STAT, 32'h1);
        end
        check("irq_disabled", 32'(timer_irq), 32'h0);

        // irq and W1C
        wr(A_CTRL, 32'h3);
        check("irq_rise", 32'(timer_irq), 32'h1);
        wr(A_STAT, 32'h0);
        rd_chk("w0_no_effect", A_STAT, 32'h1);
        wr(A_STAT, 32'h1);
        check("irq_fall", 32'(timer_irq), 32'h0);
        rd_chk("stat_cleared", A_STAT, 32'h0);
        // Next reload lands exactly on the W1C write below
        repeat (8) @(posedge clk);
        #1;
        rd_chk("cnt_before_race", A_CNT, 32'd3);
        wr(A_STAT, 32'h1);
        rd_chk("w1c_race_match", A_STAT, 32'h1);
        check("w1c_race_irq", 32'(timer_irq), 32'h1);
        rd_chk("w1c_race_cnt", A_CNT, 32'h0);

        // CNT write in a tick cycle wins
        repeat (2) @(posedge clk);
        #1;
        wr(A_CNT, 32'd100);
        rd_chk("cnt_wr_tick", A_CNT, 32'd100);
        repeat (2) @(posedge clk);
        #1;
        rd_chk("cnt_hold", A_CNT, 32'd100);
        step();
        rd_chk("cnt_inc", A_CNT, 32'd101);
        wr(A_STAT, 32'h1);
        rd_chk("stat_clr2", A_STAT, 32'h0);

        // Wrap with CMP=0, PRESC=0
        wr(A_CTRL, 32'h0);
        wr(A_PRESC, 32'h0);
        wr(A_CMP, 32'h0);
        wr(A_CNT, 32'hFFFF_FFFF);
        step();
        rd_chk("cnt_frozen", A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h3);
        step();
        rd_chk("wrap_cnt", A_CNT, 32'h0);
        rd_chk("wrap_no_match", A_STAT, 32'h0);
        check("wrap_no_irq", 32'(timer_irq), 32'h0);
        step();
        rd_chk("reload_match", A_STAT, 32'h1);
        check("reload_irq", 32'(timer_irq), 32'h1);

        // Unused offsets and read-only GPIO_IN
        wr(32'h0000_8009, 32'hFFFF_FFFF);
        wr(A_GPI, 32'h0000_00FF);
        rd_chk("gpi_ro", A_GPI, 32'h3C);
        for (int o = 7; o <= 15; o++) begin
            rd_chk($sformatf("unused_off%0d", o), 32'h0000_8000 | 32'(o), 32'h0);
        end

        // Asynchronous reset mid-count
        wr(A_CMP, 32'h0000_FFFF);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gpio_out", 32'(gpio_out), 32'h0);
        check("arst_irq", 32'(timer_irq), 32'h0);
        rd_chk("arst_cnt", A_CNT, 32'h0);
        rd_chk("arst_ctrl", A_CTRL, 32'h0);
        rd_chk("arst_presc", A_PRESC, 32'h0);
        rd_chk("arst_cmp", A_CMP, 32'h0);
        rd_chk("arst_stat", A_STAT, 32'h0);
        rd_chk("arst_gpi", A_GPI, 32'h0);
        rd_chk("arst_gpo_rd", A_GPO, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd_chk("idle_cnt", A_CNT, 32'h0);
        check("idle_irq", 32'(timer_irq), 32'h0);
        rd_chk("ram_kept", 32'd5, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
